axi4s_pkt_checker: RTL

AXI4-Stream receiving endpoint that consumes packets from any stream master in the design or bench. It checks every byte against a deterministic incrementing pattern and enforces packet length and `tkeep` rules. It exposes packet, byte and error counters, and can optionally apply pseudo-random backpressure. It is the sink-side counterpart to the stream driver/generator and terminates a stream during loopback and soak tests.

---
 rtl/axi4s_pkt_checker_if.sv | 25 ++
 rtl/axi4s_pkt_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axi4s_pkt_checker_if.sv
// AXI4-Stream bus bundle for the packet checker.
//   master modport : drives tvalid/tdata/tkeep/tlast/tid, samples tready
//   slave  modport : samples tvalid/tdata/tkeep/tlast/tid, drives tready
// Byte lane i of s_tdata is s_tdata[8i+7:8i] and is qualified by s_tkeep[i].
interface axi4s_pkt_checker_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 4
);
  logic                     s_tvalid;
  logic                     s_tready;
  logic [TDATA_WIDTH-1:0]   s_tdata;
  logic [TDATA_WIDTH/8-1:0] s_tkeep;
  logic                     s_tlast;
  logic [TID_WIDTH-1:0]     s_tid;

  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tid,
    input  s_tready
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tid,
    output s_tready
  );
endinterface

// File: rtl/axi4s_pkt_checker.sv
// AXI4-Stream packet checker (sink endpoint).
// Consumes packets and checks every kept byte against an incrementing
// pattern whose start value (seed) is the low byte of pkt_cnt when the
// packet's first beat is accepted. Also checks tkeep shape and packet length.
//
// Ports:
//   aclk, aresetn        : clock, asynchronous active-low reset
//   s (slave modport)    : AXI4-Stream input; s_tready is registered
//   cfg_enable           : allows s_tready (takes effect from the next cycle)
//   cfg_clear            : pulse, zeroes counters and err_flag (wins over updates)
//   cfg_bp_level         : backpressure strength (used only with backpressure)
//   pkt_cnt/byte_cnt     : completed packets / accepted kept bytes
//   err_cnt/err_flag     : erroneous packets (saturating) / sticky error
//   last_tid             : s_tid of the most recently completed packet
//
// Build option: define AXI4S_PKT_CHECKER_BACKPRESSURE_EN to gate s_tready
// with a 16-bit LFSR (x^16+x^14+x^13+x^11+1). Without it s_tready follows
// cfg_enable and cfg_bp_level is ignored.
module axi4s_pkt_checker #(
  parameter int          TDATA_WIDTH = 32,
  parameter int          TID_WIDTH   = 4,
  parameter int          MAX_BEATS   = 256,
  parameter int          CNT_WIDTH   = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi4s_pkt_checker_if.slave   s,
  input  logic                 cfg_enable,
  input  logic                 cfg_clear,
  input  logic [3:0]           cfg_bp_level,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] byte_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 err_flag,
  output logic [TID_WIDTH-1:0] last_tid
);
  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int PC_W   = $clog2(KEEP_W + 1);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DROP} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             seed_q, seed_d;
  logic [7:0]             byte_idx_q, byte_idx_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic                   err_flag_q, err_flag_d;
  logic [TID_WIDTH-1:0]   last_tid_q, last_tid_d;
  logic                   tready_q, tready_d;
  logic                   err_pulse;

  function automatic logic [PC_W-1:0] popcount(input logic [KEEP_W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_W; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  logic                accept;
  logic [PC_W-1:0]     kept_cnt;
  logic [7:0]          cur_seed;
  logic [7:0]          cur_idx;
  logic [BEAT_W-1:0]   beat_num;
  logic [KEEP_W-1:0]   keep_inc;
  logic [KEEP_W-1:0]   lane_bad;
  logic                keep_err, len_err, data_err, beat_err;

  assign s.s_tready = tready_q;
  assign accept     = s.s_tvalid & tready_q;
  assign kept_cnt   = popcount(s.s_tkeep);

  // The first beat of a packet is checked in IDLE, so it uses the seed and
  // index it is about to latch rather than the stale registers.
  assign cur_seed = (state_q == ST_IDLE) ? pkt_cnt_q[7:0] : seed_q;
  assign cur_idx  = (state_q == ST_IDLE) ? 8'd0 : byte_idx_q;
  assign beat_num = (state_q == ST_IDLE) ? BEAT_W'(1) : beat_q + BEAT_W'(1);

  // Expected byte of lane gi counts only the kept lanes below it.
  for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_lane
    localparam logic [KEEP_W-1:0] BELOW = KEEP_W'((65'd1 << gi) - 65'd1);
    logic [7:0] exp_byte;
    assign exp_byte     = cur_seed + cur_idx + 8'(popcount(s.s_tkeep & BELOW));
    assign lane_bad[gi] = s.s_tkeep[gi] & (s.s_tdata[8*gi +: 8] != exp_byte);
  end

  // A mask is contiguous from lane 0 exactly when mask & (mask+1) == 0.
  assign keep_inc = s.s_tkeep + KEEP_W'(1);
  assign keep_err = (s.s_tkeep == '0) | (|(s.s_tkeep & keep_inc)) |
                    (!s.s_tlast & !(&s.s_tkeep));
  assign len_err  = !s.s_tlast & (beat_num == BEAT_W'(MAX_BEATS));
  assign data_err = |lane_bad;
  assign beat_err = keep_err | len_err | data_err;

  // Packet FSM. The first error of a packet always leaves the checking
  // states, so err_pulse fires at most once per packet.
  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    byte_idx_d = byte_idx_q;
    beat_d     = beat_q;
    err_pulse  = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE, ST_PKT: begin
          seed_d     = cur_seed;
          byte_idx_d = cur_idx + 8'(kept_cnt);
          beat_d     = beat_num;
          if (beat_err) begin
            err_pulse = 1'b1;
            state_d   = s.s_tlast ? ST_IDLE : ST_DROP;
          end else begin
            state_d   = s.s_tlast ? ST_IDLE : ST_PKT;
          end
        end
        default: begin
          if (s.s_tlast) state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q + CNT_WIDTH'(accept & s.s_tlast);
    byte_cnt_d = byte_cnt_q + (accept ? CNT_WIDTH'(kept_cnt) : '0);
    err_cnt_d  = err_cnt_q;
    if (err_pulse && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    err_flag_d = err_flag_q | err_pulse;
    last_tid_d = (accept & s.s_tlast) ? s.s_tid : last_tid_q;
    if (cfg_clear) begin
      pkt_cnt_d  = '0;
      byte_cnt_d = '0;
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end
  end

`ifdef AXI4S_PKT_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  // Right-shifting Fibonacci form: taps 16,14,13,11 map to bits 0,2,3,5.
  assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign tready_d = cfg_enable & (lfsr_q[3:0] >= cfg_bp_level);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_bp_level, LFSR_SEED};
  assign tready_d   = cfg_enable;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      seed_q     <= '0;
      byte_idx_q <= '0;
      beat_q     <= '0;
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      last_tid_q <= '0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      byte_idx_q <= byte_idx_d;
      beat_q     <= beat_d;
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      last_tid_q <= last_tid_d;
      tready_q   <= tready_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign byte_cnt = byte_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;
  assign last_tid = last_tid_q;
endmodule
